// File: rtl/mem_block_mover.sv
// DMA-style word copy/fill engine driving the data-memory port; copy takes 1+2N busy cycles, fill 1+N.
// All outputs registered; no backpressure, the memory is assumed to accept one access per cycle.
`timescale 1ns/1ps
module mem_block_mover #(
  parameter int RAM_SIZE = 256,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, DONE} state_t;

  localparam logic [31:0] LIMIT = 32'(RAM_SIZE);

  state_t           state, state_n;
  logic             mode_r, mode_n;
  logic [31:0]      src_r, src_n, dst_r, dst_n, fill_r, fill_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n, err_n, rd_n, wr_n, finish;
  logic [31:0]      addr_n, wdata_n;

  // Strobes are decided on entry to READ/WRITE so they can be registered;
  // an out-of-range address enters the state with its strobe held low.
  always_comb begin
    state_n = state;
    mode_n  = mode_r;
    src_n   = src_r;
    dst_n   = dst_r;
    fill_n  = fill_r;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = err;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CHECK;
          mode_n  = mode;
          src_n   = src_addr;
          dst_n   = dst_addr;
          cnt_n   = len;
          fill_n  = fill_data;
          busy_n  = 1'b1;
          err_n   = 1'b0;
        end
      end
      CHECK: begin
        if (cnt == '0) begin
          finish = 1'b1;
        end else if ((!mode_r && src_r[1:0] != 2'b00) || dst_r[1:0] != 2'b00) begin
          finish = 1'b1;
          err_n  = 1'b1;
        end else if (mode_r) begin
          state_n = WRITE;
          wr_n    = (dst_r < LIMIT);
          addr_n  = dst_r;
          wdata_n = fill_r;
        end else begin
          state_n = READ;
          rd_n    = (src_r < LIMIT);
          addr_n  = src_r;
        end
      end
      READ: begin
        if (src_r >= LIMIT) begin
          finish = 1'b1;
          err_n  = 1'b1;
        end else begin
          state_n = WRITE;
          wr_n    = (dst_r < LIMIT);
          addr_n  = dst_r;
          wdata_n = mem_rdata;
        end
      end
      WRITE: begin
        if (dst_r >= LIMIT) begin
          finish = 1'b1;
          err_n  = 1'b1;
        end else begin
          src_n = src_r + 32'd4;
          dst_n = dst_r + 32'd4;
          cnt_n = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            finish = 1'b1;
          end else if (mode_r) begin
            state_n = WRITE;
            wr_n    = (dst_n < LIMIT);
            addr_n  = dst_n;
            wdata_n = fill_r;
          end else begin
            state_n = READ;
            rd_n    = (src_n < LIMIT);
            addr_n  = src_n;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (finish) begin
      state_n = DONE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      src_r     <= '0;
      dst_r     <= '0;
      fill_r    <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      mode_r    <= mode_n;
      src_r     <= src_n;
      dst_r     <= dst_n;
      fill_r    <= fill_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      mem_rd    <= rd_n;
      mem_wr    <= wr_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: table vectors, reset/hold-start sequences and random transfers against a word-level model.
`timescale 1ns/1ps
module tb_mem_block_mover;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0, fill_data = '0;
  logic [7:0]  len = '0;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] exp_mem [64];
  logic        init_req = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} acc_t;
  acc_t exp_q[$], obs_q[$];
  logic m_err;
  int   m_lat;

  typedef struct {
    logic md; logic [31:0] s, d; logic [7:0] n; logic [31:0] f; bit hold;
    int lat; logic e; int nrd, nwr;
  } vec_t;
  vec_t tbl[10];

  mem_block_mover #(.RAM_SIZE(256), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_rd && mem_addr < 32'd256) ? mem[mem_addr[7:2]] : 32'h0;

  // The memory shares the system reset, so a write in a reset cycle is dropped.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i + 1);
    end else if (reset && mem_wr && mem_addr < 32'd256) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk({name, "_mem"}, bad, 0);
  endtask

  // Word-level reference: ascending word loop, range-checked, updating exp_mem in place.
  task automatic model(input logic md, input logic [31:0] s, input logic [31:0] d,
                       input logic [7:0] n, input logic [31:0] f);
    logic [31:0] sa, da, w;
    exp_q.delete();
    m_err = 1'b0;
    if (n != 0 && ((!md && s[1:0] != 0) || d[1:0] != 0)) m_err = 1'b1;
    else begin
      for (int i = 0; i < int'(n); i++) begin
        sa = s + 32'(4 * i);
        da = d + 32'(4 * i);
        if (md) w = f;
        else begin
          if (sa >= 32'd256) begin m_err = 1'b1; break; end
          exp_q.push_back('{1'b0, sa, 32'h0});
          w = exp_mem[sa[7:2]];
        end
        if (da >= 32'd256) begin m_err = 1'b1; break; end
        exp_q.push_back('{1'b1, da, w});
        exp_mem[da[7:2]] = w;
      end
    end
    if (n == 0 || (m_err && exp_q.size() == 0 && ((!md && s[1:0] != 0) || d[1:0] != 0))) m_lat = 2;
    else if (m_err) m_lat = -1;
    else m_lat = 2 + (md ? int'(n) : 2 * int'(n));
  endtask

  task automatic run_xfer(input string tag, input logic md, input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] n, input logic [31:0] f, input bit hold,
                          output int lat, output logic e, output int nrd, output int nwr);
    int ndone = 0, nbusy = 0, both = 0, oob = 0, first_bad = -1;
    logic err_after = 1'b0;
    model(md, s, d, n, f);
    obs_q.delete();
    lat = -1; e = 1'bx; nrd = 0; nwr = 0;
    @(negedge clk);
    mode = md; src_addr = s; dst_addr = d; len = n; fill_data = f; start = 1'b1;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, "_err_clr"}, err, 1'b0);
      if (mem_rd && mem_wr) both++;
      if (mem_rd) begin nrd++; obs_q.push_back('{1'b0, mem_addr, 32'h0}); end
      if (mem_wr) begin nwr++; obs_q.push_back('{1'b1, mem_addr, mem_wdata}); end
      if (mem_wr && mem_addr >= 32'd256) oob++;
      if (busy) nbusy++;
      if (done) begin ndone++; if (lat < 0) begin lat = cyc; e = err; end end
      if (lat >= 0 && cyc == lat + 3) err_after = err;
      if (!hold || (lat >= 0 && cyc > lat)) start = 1'b0;
      mode = 1'($urandom); src_addr = $urandom; dst_addr = $urandom;
      len = 8'($urandom); fill_data = $urandom;
      if (lat >= 0 && cyc >= lat + 4) break;
    end
    start = 1'b0;
    if (lat < 0) begin
      chk({tag, "_timeout"}, 1, 0);
      return;
    end
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_busy_cyc"}, nbusy, lat - 1);
    chk({tag, "_rd_wr_both"}, both, 0);
    chk({tag, "_wr_oob"}, oob, 0);
    chk({tag, "_err_model"}, e, m_err);
    chk({tag, "_err_sticky"}, err_after, m_err);
    if (m_lat >= 0) chk({tag, "_lat_model"}, lat, m_lat);
    chk({tag, "_acc_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (first_bad < 0 && obs_q[i] !== exp_q[i]) first_bad = i;
    chk({tag, "_acc_seq"}, first_bad, -1);
    chk_mem(tag);
  endtask

  initial begin
    int lat, nrd, nwr, wcnt;
    logic e;
    bit hit;
    tbl[0] = '{1'b0, 32'h00, 32'h40, 8'd4, 32'h0,        1'b0, 10, 1'b0, 4, 4};
    tbl[1] = '{1'b1, 32'h00, 32'h80, 8'd3, 32'hDEADBEEF, 1'b0,  5, 1'b0, 0, 3};
    tbl[2] = '{1'b1, 32'h00, 32'hF8, 8'd4, 32'h55AA55AA, 1'b0, -1, 1'b1, 0, 2};
    tbl[3] = '{1'b0, 32'h00, 32'h40, 8'd0, 32'h0,        1'b0,  2, 1'b0, 0, 0};
    tbl[4] = '{1'b0, 32'h02, 32'h40, 8'd3, 32'h0,        1'b0,  2, 1'b1, 0, 0};
    tbl[5] = '{1'b0, 32'h10, 32'h20, 8'd2, 32'h0,        1'b0,  6, 1'b0, 2, 2};
    tbl[6] = '{1'b0, 32'hF8, 32'h00, 8'd4, 32'h0,        1'b0, -1, 1'b1, 2, 2};
    tbl[7] = '{1'b1, 32'h00, 32'h41, 8'd2, 32'h12345678, 1'b0,  2, 1'b1, 0, 0};
    tbl[8] = '{1'b0, 32'h40, 32'h60, 8'd3, 32'h0,        1'b1,  8, 1'b0, 3, 3};
    tbl[9] = '{1'b0, 32'h00, 32'h04, 8'd3, 32'h0,        1'b0,  8, 1'b0, 3, 3};

    for (int i = 0; i < 64; i++) exp_mem[i] = 32'(i + 1);
    init_req = 1'b1;
    repeat (2) @(negedge clk);
    init_req = 1'b0;
    chk("rst_ctrl", {busy, done, err, mem_rd, mem_wr}, 5'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_xfer(tag, tbl[i].md, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].f, tbl[i].hold, lat, e, nrd, nwr);
      if (tbl[i].lat >= 0) chk({tag, "_lat"}, lat, tbl[i].lat);
      chk({tag, "_err"}, e, tbl[i].e);
      chk({tag, "_nrd"}, nrd, tbl[i].nrd);
      chk({tag, "_nwr"}, nwr, tbl[i].nwr);
      if (i == 0)
        chk("v0_dst_words", {mem[16], mem[17], mem[18], mem[19]},
            {32'd1, 32'd2, 32'd3, 32'd4});
    end

    // Reset asserted during the second WRITE of a 4-word copy.
    exp_mem[48] = exp_mem[0];
    @(negedge clk);
    mode = 1'b0; src_addr = 32'h0; dst_addr = 32'hC0; len = 8'd4; start = 1'b1;
    wcnt = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_wr) wcnt++;
      if (mem_wr && wcnt == 2) begin hit = 1'b1; reset = 1'b0; break; end
    end
    chk("mid_rst_reached", hit, 1'b1);
    @(negedge clk);
    chk("mid_rst_ctrl", {busy, done, err, mem_rd, mem_wr}, 5'b0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    nwr = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done || busy || mem_rd || mem_wr) nwr++;
    end
    chk("mid_rst_quiet", nwr, 0);
    chk_mem("mid_rst");
    run_xfer("post_rst", 1'b0, 32'h00, 32'hC0, 8'd4, 32'h0, 1'b0, lat, e, nrd, nwr);
    chk("post_rst_lat", lat, 10);

    for (int r = 0; r < 40; r++) begin
      logic        md;
      logic [31:0] s, d;
      logic [7:0]  n;
      md = 1'($urandom);
      s  = 32'($urandom_range(0, 63) * 4);
      d  = 32'($urandom_range(0, 63) * 4);
      n  = 8'($urandom_range(0, 10));
      if (r % 8 == 0) begin s[1:0] = 2'($urandom_range(1, 3)); end
      if (r % 8 == 3) begin d[1:0] = 2'($urandom_range(1, 3)); end
      if (r % 8 == 5) begin n = 8'($urandom_range(20, 80)); end
      run_xfer($sformatf("rnd%0d", r), md, s, d, n, $urandom, bit'($urandom_range(0, 1)),
               lat, e, nrd, nwr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Bus initiator that drives the data-memory rd/wr/addr/wdata/rdata port to copy or fill a block of words without CPU involvement.
- Sits between a control register block (start/mode/addresses/length) and the data memory's port, muxed ahead of the CPU's load/store path.
- Uses byte addresses, word aligned, in ascending order. The memory's read data is combinational, so it is sampled in the same cycle rd is asserted.

Parameters:
- RAM_SIZE, 256, byte-address limit; any access with address >= RAM_SIZE is an error.
- LEN_W, 8, width of the word-count input.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = copy (src to dst), 1 = fill (fill_data to dst)
- src_addr  in  32  source byte address; ignored in fill mode
- dst_addr  in  32  destination byte address
- len  in  LEN_W  number of words to transfer
- fill_data  in  32  word written in fill mode
- busy  out  1  high from the cycle after start is accepted until DONE is entered
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag; cleared when the next start is accepted
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr/mem_rd

Behaviour:
- Reset: when reset==0 at a rising edge, state=IDLE and busy, done, err, mem_rd, mem_wr are 0; mem_addr and mem_wdata are 0. This holds mid-transfer too: the transfer is abandoned, already-written words remain, no done pulse.
- States: IDLE, CHECK, READ, WRITE, DONE. All outputs are registered.
- IDLE: if start==1, latch mode, src, dst, len and fill_data into internal regs, clear err, go to CHECK. start is ignored in every other state.
- CHECK (1 cycle, busy=1):
  - If len==0, go to DONE with err=0.
  - Else if src[1:0]!=0 (copy mode only) or dst[1:0]!=0, go to DONE with err=1.
  - Else the word counter = len; go to READ (copy) or WRITE (fill).
- READ (1 cycle): mem_rd=1, mem_addr=cur_src, mem_wr=0. At the closing edge, capture mem_rdata into the data buffer; go to WRITE.
  - If cur_src >= RAM_SIZE, no access is issued (mem_rd=0); set err=1 and go to DONE.
- WRITE (1 cycle): mem_wr=1, mem_addr=cur_dst, mem_wdata = buffer (copy) or fill_data (fill). At the closing edge:
  - cur_dst += 4; cur_src += 4; counter -= 1.
  - If counter reaches 0, go to DONE; else go to READ (copy) or WRITE (fill).
  - If cur_dst >= RAM_SIZE, no access is issued (mem_wr=0); set err=1 and go to DONE.
- DONE (1 cycle): done=1, busy=0, mem_rd=mem_wr=0. Next state is IDLE. A start in DONE is ignored.
- mem_rd and mem_wr are never high in the same cycle.
- When idle, mem_addr holds its last value.
- Latency for len=N with no error:
  - copy: busy for 1+2N cycles, then done.
  - fill: busy for 1+N cycles, then done.
- Address arithmetic is 32-bit unsigned with wrap. A wrapped address is >= RAM_SIZE in practice, so it ends as err.
- Overlap: copy is strictly ascending, word by word (read then write). With dst>src overlapping, source words are overwritten before they are read. This is the defined result; there is no hazard handling.
- Inputs changing while busy have no effect, because all operands are latched in IDLE.

Test Plan:
- Copy: memory words 0x00..0x0C = 1,2,3,4; start, mode=0, src=0x00, dst=0x40, len=4.
  - Expect 4 READ/WRITE pairs with addresses 0x00/0x40 .. 0x0C/0x4C.
  - Memory 0x40..0x4C = 1,2,3,4; done pulses exactly once, 10 cycles after start; err=0.
- Fill: mode=1, dst=0x80, len=3, fill_data=0xDEADBEEF.
  - Expect writes at 0x80, 0x84, 0x88; no mem_rd; done 5 cycles after start.
- Boundary and zero length:
  - dst=0xF8, len=4 (fill): writes at 0xF8 and 0xFC only, then err=1 and done; 0x100 is never driven with mem_wr=1.
  - len=0: done 2 cycles after start, no memory strobes, err=0.
- Misalignment: copy with src=0x02 -> err=1 and done in DONE, zero memory strobes. The next valid start clears err.
- Reset mid-copy:
  - Stimulus: reset low during the 2nd WRITE of a len=4 copy.
  - Next edge: all outputs 0, state IDLE, no done pulse, only the 1st destination word modified.
  - A new start afterwards completes normally.
- start held high throughout a transfer: exactly one transfer and one done pulse; start in the DONE cycle is ignored.
